// File: rtl/ssd_pkg.sv
// Shared types and constants for the
// seven-segment display scheduler.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    ADVANCE = 2'd2,
    MANUAL  = 2'd3
  } ssd_state_t;

  localparam logic [12:0] SSD_MAX = 13'd8191;

  localparam int DWELL_DEFAULT = 100_000_000;

endpackage

// File: rtl/rr_next_valid.sv
// Round-robin search for the next valid index,
// starting after cur and ending on cur itself.
module rr_next_valid #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next,
  output logic             found
);

  logic [SEL_W-1:0] idx;

  // Farthest candidate first so the nearest one wins.
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = cur + SEL_W'(k);
      if (valid[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_display_scheduler.sv
// Time-shares the 4-digit display between sources:
// auto round-robin with dwell, or manual select.
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VAL_W   = 32,
  parameter int DWELL   = DWELL_DEFAULT,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         man_sel,
  input  logic                     freeze,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*VAL_W-1:0] src_vals,
  output logic [12:0]              num,
  output logic [SEL_W-1:0]         cur_src,
  output logic                     ovf,
  output logic                     switch_pulse
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DWELL - 1);

  ssd_state_t       state_q, state_d;
  logic [SEL_W-1:0] cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] nxt;
  logic             found;
  logic [VAL_W-1:0] v;
  logic             over;
  logic [12:0]      num_d;

  rr_next_valid #(
    .N     (NUM_SRC),
    .SEL_W (SEL_W)
  ) u_rr (
    .valid (src_valid),
    .cur   (cur_src),
    .next  (nxt),
    .found (found)
  );

  // Next state, grant and dwell counter; mode wins.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_src;
    cnt_d   = cnt_q;
    if (mode) begin
      state_d = MANUAL;
      cur_d   = man_sel;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|src_valid)
            state_d = ADVANCE;
        end
        ADVANCE: begin
          if (found) begin
            cur_d   = nxt;
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end
        SHOW: begin
          if (!src_valid[cur_src])
            state_d = ADVANCE;
          else if (freeze)
            cnt_d = cnt_q;
          else if (cnt_q == LAST)
            state_d = ADVANCE;
          else
            cnt_d = cnt_q + 1'b1;
        end
        MANUAL: begin
          state_d = ADVANCE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Live value of the shown source, clamped.
  always_comb begin
    v     = src_vals[cur_src*VAL_W +: VAL_W];
    over  = v > VAL_W'(SSD_MAX);
    num_d = over ? SSD_MAX : v[12:0];
  end

  // State, index and dwell registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_src <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_src <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Display outputs trail cur_src by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num          <= '0;
      ovf          <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= cur_d != cur_src;
      if (state_q == IDLE) begin
        num <= '0;
        ovf <= 1'b0;
      end else begin
        num <= num_d;
        ovf <= over;
      end
    end
  end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed bench for ssd_display_scheduler
// with DWELL=4 (5-cycle period per source).
module tb_ssd_display_scheduler;

  localparam int NS = 4;
  localparam int VW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] man_sel;
  logic          freeze;
  logic [NS-1:0] src_valid;
  logic [NS*VW-1:0] src_vals;
  logic [12:0]   num;
  logic [SW-1:0] cur_src;
  logic          ovf;
  logic          switch_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  int vals [4] = '{10, 20, 30, 40};
  int seq  [4] = '{2, 3, 0, 1};
  int prev;

  ssd_display_scheduler #(
    .NUM_SRC (NS),
    .VAL_W   (VW),
    .DWELL   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .man_sel      (man_sel),
    .freeze       (freeze),
    .src_valid    (src_valid),
    .src_vals     (src_vals),
    .num          (num),
    .cur_src      (cur_src),
    .ovf          (ovf),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    man_sel   = '0;
    freeze    = 1'b0;
    src_valid = 4'b1111;
    src_vals  = {32'd40, 32'd30, 32'd20, 32'd10};
    tick(2);
    chk("rst_num", 32'(num), 0);
    chk("rst_cur", 32'(cur_src), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_pulse", 32'(switch_pulse), 0);
    rst = 1'b0;

    // 1: round robin from IDLE, first grant is 1
    tick(1);
    chk("t1_idle_num", 32'(num), 0);
    chk("t1_idle_cur", 32'(cur_src), 0);
    tick(1);
    chk("t1_g1_cur", 32'(cur_src), 1);
    chk("t1_g1_pulse", 32'(switch_pulse), 1);
    tick(1);
    chk("t1_g1_num", 32'(num), 20);
    chk("t1_g1_pulse0", 32'(switch_pulse), 0);
    prev = 1;
    for (int i = 0; i < 4; i++) begin
      tick(3);
      chk("t1_hold_cur", 32'(cur_src), 32'(prev));
      chk("t1_hold_num", 32'(num), 32'(vals[prev]));
      chk("t1_hold_pulse", 32'(switch_pulse), 0);
      tick(1);
      chk("t1_sw_cur", 32'(cur_src), 32'(seq[i]));
      chk("t1_sw_pulse", 32'(switch_pulse), 1);
      tick(1);
      chk("t1_sw_num", 32'(num), 32'(vals[seq[i]]));
      chk("t1_sw_pulse0", 32'(switch_pulse), 0);
      prev = seq[i];
    end

    // 2: clamp on source 1, then exact max
    src_vals[1*VW +: VW] = 32'd9000;
    tick(1);
    chk("t2_clamp_num", 32'(num), 8191);
    chk("t2_clamp_ovf", 32'(ovf), 1);
    src_vals[1*VW +: VW] = 32'd8191;
    tick(1);
    chk("t2_max_num", 32'(num), 8191);
    chk("t2_max_ovf", 32'(ovf), 0);
    src_vals[1*VW +: VW] = 32'd20;

    // 3: sparse valid set 0101
    src_valid = 4'b0101;
    tick(2);
    chk("t3_g2_cur", 32'(cur_src), 2);
    chk("t3_g2_pulse", 32'(switch_pulse), 1);
    tick(4);
    chk("t3_g2_hold", 32'(cur_src), 2);
    chk("t3_g2_num", 32'(num), 30);
    tick(1);
    chk("t3_g0_cur", 32'(cur_src), 0);
    chk("t3_g0_pulse", 32'(switch_pulse), 1);
    tick(5);
    chk("t3_g2b_cur", 32'(cur_src), 2);
    tick(1);
    chk("t3_g2b_num", 32'(num), 30);
    src_valid = 4'b0001;
    tick(1);
    chk("t3_drop_adv", 32'(cur_src), 2);
    tick(1);
    chk("t3_drop_cur", 32'(cur_src), 0);
    chk("t3_drop_pulse", 32'(switch_pulse), 1);

    // 4: nothing valid, then only source 3
    src_valid = 4'b0000;
    tick(3);
    chk("t4_idle_num", 32'(num), 0);
    chk("t4_idle_cur", 32'(cur_src), 0);
    chk("t4_idle_ovf", 32'(ovf), 0);
    tick(3);
    chk("t4_idle_num2", 32'(num), 0);
    src_valid = 4'b1000;
    tick(2);
    chk("t4_g3_cur", 32'(cur_src), 3);
    chk("t4_g3_pulse", 32'(switch_pulse), 1);
    tick(1);
    chk("t4_g3_num", 32'(num), 40);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t4_regrant_cur", 32'(cur_src), 3);
      chk("t4_regrant_pulse",
          32'(switch_pulse), 0);
    end

    // 5: manual select of an invalid source
    mode    = 1'b1;
    man_sel = 2'd2;
    freeze  = 1'b1;
    tick(1);
    chk("t5_man_cur", 32'(cur_src), 2);
    chk("t5_man_pulse", 32'(switch_pulse), 1);
    chk("t5_man_num_lag", 32'(num), 40);
    tick(1);
    chk("t5_man_num", 32'(num), 30);
    chk("t5_man_pulse0", 32'(switch_pulse), 0);
    tick(3);
    chk("t5_man_hold_cur", 32'(cur_src), 2);
    chk("t5_man_hold_num", 32'(num), 30);
    man_sel = 2'd0;
    tick(1);
    chk("t5_sel0_cur", 32'(cur_src), 0);
    chk("t5_sel0_pulse", 32'(switch_pulse), 1);
    tick(1);
    chk("t5_sel0_num", 32'(num), 10);
    mode   = 1'b0;
    freeze = 1'b0;
    tick(1);
    chk("t5_adv_cur", 32'(cur_src), 0);
    chk("t5_adv_pulse", 32'(switch_pulse), 0);
    tick(1);
    chk("t5_auto_cur", 32'(cur_src), 3);
    chk("t5_auto_pulse", 32'(switch_pulse), 1);

    // 6: async reset mid-SHOW while frozen
    src_valid = 4'b1111;
    freeze    = 1'b1;
    src_vals[3*VW +: VW] = 32'd9000;
    tick(1);
    chk("t6_pre_num", 32'(num), 8191);
    chk("t6_pre_ovf", 32'(ovf), 1);
    tick(6);
    chk("t6_frozen_cur", 32'(cur_src), 3);
    rst = 1'b1;
    #1;
    chk("t6_rst_num", 32'(num), 0);
    chk("t6_rst_cur", 32'(cur_src), 0);
    chk("t6_rst_ovf", 32'(ovf), 0);
    chk("t6_rst_pulse", 32'(switch_pulse), 0);
    tick(1);
    rst    = 1'b0;
    freeze = 1'b0;
    tick(1);
    chk("t6_idle_cur", 32'(cur_src), 0);
    chk("t6_idle_num", 32'(num), 0);
    tick(1);
    chk("t6_g1_cur", 32'(cur_src), 1);
    chk("t6_g1_pulse", 32'(switch_pulse), 1);
    tick(1);
    chk("t6_g1_num", 32'(num), 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
